// File: rtl/capture_wr_pkg.sv
// Shared types and constants for the capture write-packing stage.
package capture_wr_pkg;

   // Burst FSM: wait for enough data, request, stream words, report flush completion.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Upper half used when an odd sample is flushed on its own.
   localparam logic [15:0] PAD_HALF = 16'h0000;

   // Width of wr_len and of the per-burst pop counter.
   localparam int LEN_W = 8;

endpackage

// File: rtl/capture_wr_fifo.sv
// Single-clock 32-bit FIFO with a synchronous clear. Extra pointer bit gives full/empty.
module capture_wr_fifo #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   fill
);

   logic [31:0] mem [2**AW];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_wr;
   logic        do_rd;

   assign fill    = wr_ptr_q - rd_ptr_q;
   assign full    = fill[AW];
   assign empty   = (fill == '0);
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   // Pointer update; a write into a full FIFO is refused even if a pop happens too.
   always_comb begin
      do_wr    = wr_en & ~full & ~clr;
      do_rd    = rd_en & ~empty & ~clr;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, written only for accepted words.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/capture_wr_pack.sv
// Packs 16-bit capture samples into 32-bit words, buffers them and issues
// fixed-length SDRAM burst write requests; flushes residue on capture_done.
//
// Handshake: wr_req rises with wr_addr/wr_len already valid and all three stay
// stable until a cycle where wr_req && wr_ack; after that the controller pops
// words with wr_data_rd, each pop consuming the current wr_data. A pop with the
// FIFO empty or outside a burst is ignored.
module capture_wr_pack
   import capture_wr_pkg::*;
#(
   parameter int FIFO_AW = 6,
   parameter int BURST   = 16
) (
   input  logic              core_clk,
   input  logic              core_rst_n,
   input  logic              sample_en,
   input  logic              capture_valid,
   input  logic [15:0]       capture_data,
   input  logic              capture_done,
   output logic              wr_req,
   output logic [31:0]       wr_addr,
   output logic [LEN_W-1:0]  wr_len,
   input  logic              wr_ack,
   output logic [31:0]       wr_data,
   input  logic              wr_data_rd,
   output logic              overflow,
   output logic              flush_done,
   output logic [31:0]       wr_word_cnt,
   output logic [1:0]        dbg_state
);

   localparam logic [FIFO_AW:0]  BURST_FILL = (FIFO_AW+1)'(BURST);
   localparam logic [LEN_W-1:0]  BURST_LEN  = LEN_W'(BURST);

   state_t             state_q, state_d;
   logic               sample_en_q;
   logic               half_q, half_d;
   logic [15:0]        low_q, low_d;
   logic               flushing_q, flushing_d;
   logic               overflow_q, overflow_d;
   logic               wr_req_q, wr_req_d;
   logic [31:0]        wr_addr_q, wr_addr_d;
   logic [LEN_W-1:0]   wr_len_q, wr_len_d;
   logic [LEN_W-1:0]   pop_cnt_q, pop_cnt_d;
   logic               flush_done_q, flush_done_d;
   logic [31:0]        wr_word_cnt_q, wr_word_cnt_d;

   logic               session_clr;
   logic               pack_wr;
   logic [31:0]        pack_word;
   logic               pop;
   logic [31:0]        fifo_rd_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_AW:0]   fifo_fill;

   assign session_clr = sample_en & ~sample_en_q;
   assign pop = (state_q == ST_DATA) & wr_data_rd & ~fifo_empty & ~session_clr;

   capture_wr_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk     (core_clk),
      .rst_n   (core_rst_n),
      .clr     (session_clr),
      .wr_en   (pack_wr),
      .wr_data (pack_word),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .fill    (fifo_fill)
   );

   // Packer: pair samples into words; pad a lone half once flushing has begun.
   always_comb begin
      half_d     = half_q;
      low_d      = low_q;
      overflow_d = overflow_q;
      pack_wr    = 1'b0;
      pack_word  = '0;
      if (flushing_q && half_q) begin
         pack_wr   = 1'b1;
         pack_word = {PAD_HALF, low_q};
         half_d    = 1'b0;
      end else if (capture_valid && !flushing_q) begin
         if (half_q) begin
            pack_wr   = 1'b1;
            pack_word = {capture_data, low_q};
            half_d    = 1'b0;
         end else begin
            low_d  = capture_data;
            half_d = 1'b1;
         end
      end
      if (pack_wr && fifo_full) begin
         overflow_d = 1'b1;
      end
      if (session_clr) begin
         half_d     = 1'b0;
         low_d      = '0;
         overflow_d = 1'b0;
      end
   end

   // Burst FSM and counters; next-state and registered outputs computed together.
   always_comb begin
      state_d       = state_q;
      wr_req_d      = wr_req_q;
      wr_addr_d     = wr_addr_q;
      wr_len_d      = wr_len_q;
      pop_cnt_d     = pop_cnt_q;
      flush_done_d  = 1'b0;
      wr_word_cnt_d = wr_word_cnt_q;
      flushing_d    = flushing_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fifo_fill >= BURST_FILL) begin
               state_d  = ST_REQ;
               wr_req_d = 1'b1;
               wr_len_d = BURST_LEN;
            end else if (flushing_q && !half_q && (fifo_fill != '0)) begin
               state_d  = ST_REQ;
               wr_req_d = 1'b1;
               wr_len_d = LEN_W'(fifo_fill);
            end else if (flushing_q && !half_q) begin
               state_d      = ST_DONE;
               flush_done_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (wr_ack) begin
               state_d   = ST_DATA;
               wr_req_d  = 1'b0;
               pop_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (pop) begin
               pop_cnt_d     = pop_cnt_q + 1'b1;
               wr_word_cnt_d = wr_word_cnt_q + 32'd1;
               if (pop_cnt_d == wr_len_q) begin
                  wr_addr_d = wr_addr_q + 32'(wr_len_q);
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            flushing_d = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A sample arriving with capture_done is packed first, since flushing_q is still low.
      if (capture_done) begin
         flushing_d = 1'b1;
      end
      if (session_clr) begin
         state_d       = ST_IDLE;
         wr_req_d      = 1'b0;
         wr_addr_d     = '0;
         wr_len_d      = '0;
         pop_cnt_d     = '0;
         flush_done_d  = 1'b0;
         wr_word_cnt_d = '0;
         flushing_d    = 1'b0;
      end
   end

   // State registers for packer, FSM and counters.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q       <= ST_IDLE;
         sample_en_q   <= 1'b0;
         half_q        <= 1'b0;
         low_q         <= '0;
         flushing_q    <= 1'b0;
         overflow_q    <= 1'b0;
         wr_req_q      <= 1'b0;
         wr_addr_q     <= '0;
         wr_len_q      <= '0;
         pop_cnt_q     <= '0;
         flush_done_q  <= 1'b0;
         wr_word_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         sample_en_q   <= sample_en;
         half_q        <= half_d;
         low_q         <= low_d;
         flushing_q    <= flushing_d;
         overflow_q    <= overflow_d;
         wr_req_q      <= wr_req_d;
         wr_addr_q     <= wr_addr_d;
         wr_len_q      <= wr_len_d;
         pop_cnt_q     <= pop_cnt_d;
         flush_done_q  <= flush_done_d;
         wr_word_cnt_q <= wr_word_cnt_d;
      end
   end

   assign wr_req      = wr_req_q;
   assign wr_addr     = wr_addr_q;
   assign wr_len      = wr_len_q;
   assign wr_data     = fifo_empty ? 32'd0 : fifo_rd_data;
   assign overflow    = overflow_q;
   assign flush_done  = flush_done_q;
   assign wr_word_cnt = wr_word_cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_capture_wr_pack.sv
// Directed bench for capture_wr_pack: bursts, flush, overflow, stall, reset.
module tb_capture_wr_pack;

   // ---------------- clock / reset ----------------
   logic core_clk = 1'b0;
   logic core_rst_n = 1'b0;
   always #5 core_clk = ~core_clk;

   // Main instance: FIFO_AW=6, BURST=16.
   logic        sample_en = 0, capture_valid = 0, capture_done = 0;
   logic [15:0] capture_data = '0;
   logic        wr_req, overflow, flush_done;
   logic [31:0] wr_addr, wr_data, wr_word_cnt;
   logic [7:0]  wr_len;
   logic        wr_ack = 0, wr_data_rd = 0;
   logic [1:0]  dbg_state;

   // Small instance for overflow: FIFO_AW=2, BURST=4.
   logic        s_sample_en = 0, s_capture_valid = 0, s_capture_done = 0;
   logic [15:0] s_capture_data = '0;
   logic        s_wr_req, s_overflow, s_flush_done;
   logic [31:0] s_wr_addr, s_wr_data, s_wr_word_cnt;
   logic [7:0]  s_wr_len;
   logic        s_wr_ack = 0, s_wr_data_rd = 0;
   logic [1:0]  s_dbg_state;

   capture_wr_pack #(.FIFO_AW(6), .BURST(16)) dut (
      .core_clk(core_clk), .core_rst_n(core_rst_n), .sample_en(sample_en),
      .capture_valid(capture_valid), .capture_data(capture_data), .capture_done(capture_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
      .wr_data(wr_data), .wr_data_rd(wr_data_rd), .overflow(overflow),
      .flush_done(flush_done), .wr_word_cnt(wr_word_cnt), .dbg_state(dbg_state)
   );

   capture_wr_pack #(.FIFO_AW(2), .BURST(4)) dut_small (
      .core_clk(core_clk), .core_rst_n(core_rst_n), .sample_en(s_sample_en),
      .capture_valid(s_capture_valid), .capture_data(s_capture_data), .capture_done(s_capture_done),
      .wr_req(s_wr_req), .wr_addr(s_wr_addr), .wr_len(s_wr_len), .wr_ack(s_wr_ack),
      .wr_data(s_wr_data), .wr_data_rd(s_wr_data_rd), .overflow(s_overflow),
      .flush_done(s_flush_done), .wr_word_cnt(s_wr_word_cnt), .dbg_state(s_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int checks = 0;
   int errors = 0;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic session_start();
      sample_en = 1'b0;
      tick();
      sample_en = 1'b1;
      tick();
      exp_q.delete();
   endtask

   task automatic send_sample(input logic [15:0] d);
      capture_valid = 1'b1;
      capture_data  = d;
      tick();
      capture_valid = 1'b0;
   endtask

   // Sends 2*n consecutive samples starting at base; expected words go into exp_q.
   task automatic send_pairs(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         send_sample(16'(base + 2*k));
         send_sample(16'(base + 2*k + 1));
         exp_q.push_back({16'(base + 2*k + 1), 16'(base + 2*k)});
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_flush(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (flush_done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic do_ack();
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
   endtask

   task automatic pop_words(input int n);
      got_q.delete();
      for (int i = 0; i < n; i++) begin
         got_q.push_back(wr_data);
         wr_data_rd = 1'b1;
         tick();
      end
      wr_data_rd = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      core_rst_n = 1'b0;
      tick();
      tick();
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got=%b exp=0", wr_req); end
      checks++; if (wr_addr !== 32'd0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
      checks++; if (wr_len !== 8'd0) begin errors++; $display("FAIL reset_wr_len got=%h exp=0", wr_len); end
      checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
      checks++; if ({overflow, flush_done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow, flush_done}); end
      checks++; if (wr_word_cnt !== 32'd0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", wr_word_cnt); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      core_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_bursts();
      bit ok;
      logic [31:0] e;
      session_start();
      send_pairs(32, 0);
      for (int b = 0; b < 2; b++) begin
         wait_req(ok);
         checks++; if (!ok) begin errors++; $display("FAIL basic_req_timeout burst=%0d got=0 exp=1", b); end
         checks++; if (wr_addr !== 32'(16*b)) begin errors++; $display("FAIL basic_addr burst=%0d got=%0d exp=%0d", b, wr_addr, 16*b); end
         checks++; if (wr_len !== 8'd16) begin errors++; $display("FAIL basic_len burst=%0d got=%0d exp=16", b, wr_len); end
         do_ack();
         pop_words(16);
         for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_q[i] !== e) begin errors++; $display("FAIL basic_word idx=%0d got=%h exp=%h", 16*b+i, got_q[i], e); end
         end
      end
      checks++; if (wr_word_cnt !== 32'd32) begin errors++; $display("FAIL basic_word_cnt got=%0d exp=32", wr_word_cnt); end
      tick();
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL basic_no_extra_req got=%b exp=0", wr_req); end
      checks++; if (wr_addr !== 32'd32) begin errors++; $display("FAIL basic_final_addr got=%0d exp=32", wr_addr); end
   endtask

   task automatic test_odd_flush();
      bit ok;
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h00A1_00A0;
      exp_w[1] = 32'h00A3_00A2;
      exp_w[2] = 32'h0000_00A4;
      session_start();
      for (int i = 0; i < 5; i++) begin
         send_sample(16'(16'h00A0 + i));
         repeat ($urandom_range(0, 2)) tick();
      end
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL odd_early_flush_done got=%b exp=0", flush_done); end
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL odd_req_timeout got=0 exp=1"); end
      checks++; if (wr_addr !== 32'd0) begin errors++; $display("FAIL odd_addr got=%0d exp=0", wr_addr); end
      checks++; if (wr_len !== 8'd3) begin errors++; $display("FAIL odd_len got=%0d exp=3", wr_len); end
      do_ack();
      pop_words(3);
      for (int i = 0; i < 3; i++) begin
         checks++; if (got_q[i] !== exp_w[i]) begin errors++; $display("FAIL odd_word idx=%0d got=%h exp=%h", i, got_q[i], exp_w[i]); end
      end
      wait_flush(ok);
      checks++; if (!ok) begin errors++; $display("FAIL odd_flush_timeout got=0 exp=1"); end
      tick();
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL odd_flush_pulse_width got=%b exp=0", flush_done); end
      checks++; if (wr_word_cnt !== 32'd3) begin errors++; $display("FAIL odd_word_cnt got=%0d exp=3", wr_word_cnt); end
      checks++; if (wr_addr !== 32'd3) begin errors++; $display("FAIL odd_final_addr got=%0d exp=3", wr_addr); end
   endtask

   task automatic test_valid_with_done();
      bit ok;
      session_start();
      send_sample(16'h5678);
      capture_valid = 1'b1;
      capture_data  = 16'h1234;
      capture_done  = 1'b1;
      tick();
      capture_valid = 1'b0;
      capture_done  = 1'b0;
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL vd_req_timeout got=0 exp=1"); end
      checks++; if (wr_len !== 8'd1) begin errors++; $display("FAIL vd_len got=%0d exp=1", wr_len); end
      do_ack();
      pop_words(1);
      checks++; if (got_q[0] !== 32'h1234_5678) begin errors++; $display("FAIL vd_word got=%h exp=12345678", got_q[0]); end
      wait_flush(ok);
      checks++; if (!ok) begin errors++; $display("FAIL vd_flush_timeout got=0 exp=1"); end
      tick();
      checks++; if (wr_word_cnt !== 32'd1) begin errors++; $display("FAIL vd_word_cnt got=%0d exp=1", wr_word_cnt); end
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL vd_no_pad_req got=%b exp=0", wr_req); end
   endtask

   task automatic test_ack_stall();
      bit ok;
      logic [31:0] e;
      session_start();
      send_pairs(16, 16'h0100);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout got=0 exp=1"); end
      wr_data_rd = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if ({wr_req, dbg_state} !== 3'b1_01) begin errors++; $display("FAIL stall_req cyc=%0d got=%b exp=101", c, {wr_req, dbg_state}); end
         checks++; if (wr_addr !== 32'd0 || wr_len !== 8'd16) begin errors++; $display("FAIL stall_addr_len cyc=%0d got=%0d/%0d exp=0/16", c, wr_addr, wr_len); end
         checks++; if (wr_word_cnt !== 32'd0 || wr_data !== 32'h0101_0100) begin errors++; $display("FAIL stall_no_pop cyc=%0d got=%0d/%h exp=0/01010100", c, wr_word_cnt, wr_data); end
      end
      wr_data_rd = 1'b0;
      do_ack();
      pop_words(16);
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         checks++; if (got_q[i] !== e) begin errors++; $display("FAIL stall_word idx=%0d got=%h exp=%h", i, got_q[i], e); end
      end
      checks++; if (wr_word_cnt !== 32'd16) begin errors++; $display("FAIL stall_word_cnt got=%0d exp=16", wr_word_cnt); end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      session_start();
      send_pairs(16, 0);
      wait_req(ok);
      do_ack();
      pop_words(5);
      checks++; if (wr_word_cnt !== 32'd5) begin errors++; $display("FAIL rmb_pre_cnt got=%0d exp=5", wr_word_cnt); end
      core_rst_n = 1'b0;
      #1;
      checks++; if ({wr_req, overflow, flush_done, dbg_state} !== 5'b0) begin errors++; $display("FAIL rmb_flags got=%b exp=00000", {wr_req, overflow, flush_done, dbg_state}); end
      checks++; if (wr_addr !== 32'd0 || wr_len !== 8'd0) begin errors++; $display("FAIL rmb_addr_len got=%0d/%0d exp=0/0", wr_addr, wr_len); end
      checks++; if (wr_data !== 32'd0 || wr_word_cnt !== 32'd0) begin errors++; $display("FAIL rmb_data_cnt got=%h/%0d exp=0/0", wr_data, wr_word_cnt); end
      tick();
      core_rst_n = 1'b1;
      tick();
      session_start();
      send_pairs(16, 16'h0200);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmb_req_timeout got=0 exp=1"); end
      checks++; if (wr_addr !== 32'd0 || wr_len !== 8'd16) begin errors++; $display("FAIL rmb_new_addr got=%0d/%0d exp=0/16", wr_addr, wr_len); end
      do_ack();
      pop_words(16);
      checks++; if (got_q[0] !== 32'h0201_0200) begin errors++; $display("FAIL rmb_first_word got=%h exp=02010200", got_q[0]); end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [31:0] e;
      s_sample_en = 1'b0;
      tick();
      s_sample_en = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         s_capture_valid = 1'b1;
         s_capture_data  = 16'(i);
         tick();
      end
      s_capture_valid = 1'b0;
      tick();
      checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", s_overflow); end
      checks++; if (s_wr_req !== 1'b1 || s_wr_len !== 8'd4) begin errors++; $display("FAIL ovf_req got=%b/%0d exp=1/4", s_wr_req, s_wr_len); end
      s_wr_ack = 1'b1;
      tick();
      s_wr_ack = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = {16'(2*i + 1), 16'(2*i)};
         checks++; if (s_wr_data !== e) begin errors++; $display("FAIL ovf_word idx=%0d got=%h exp=%h", i, s_wr_data, e); end
         s_wr_data_rd = 1'b1;
         tick();
      end
      s_wr_data_rd = 1'b0;
      tick();
      checks++; if (s_wr_word_cnt !== 32'd4 || s_wr_req !== 1'b0) begin errors++; $display("FAIL ovf_dropped got=%0d/%b exp=4/0", s_wr_word_cnt, s_wr_req); end
      checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", s_overflow); end
      s_sample_en = 1'b0;
      tick();
      s_sample_en = 1'b1;
      tick();
      checks++; if (s_overflow !== 1'b0 || s_wr_word_cnt !== 32'd0) begin errors++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", s_overflow, s_wr_word_cnt); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_basic_bursts();
      test_odd_flush();
      test_valid_with_done();
      test_ack_stall();
      test_reset_mid_burst();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/capture_wr_pack.md
# capture_wr_pack

Downstream stage of the capture block. Packs the 16-bit `capture_data` stream into 32-bit words, buffers them in an on-chip FIFO, and issues fixed-length burst write requests with a request/ack handshake to the SDRAM write port. On `capture_done` it flushes any residual half-word and partial burst, then signals completion to the readback logic.

## Interface
- `FIFO_AW`, default 6: FIFO address width; depth is 2^FIFO_AW 32-bit words.
- `BURST`, default 16: nominal burst length in words, 1..2^FIFO_AW.

Clock and reset: one clock; reset is asynchronous and active-low.

- `core_clk`  in  1  single clock.
- `core_rst_n`  in  1  asynchronous, active-low reset.
- `sample_en`  in  1  session enable; a rising edge synchronously clears all state.
- `capture_valid`  in  1  a sample is present this cycle.
- `capture_data`  in  16  sample value.
- `capture_done`  in  1  one-cycle end-of-capture pulse; starts the flush.
- `wr_req`  out  1  burst request, held high until acknowledged.
- `wr_addr`  out  32  word address of the burst; stable while `wr_req` is high.
- `wr_len`  out  8  words in the burst, 1..BURST; stable while `wr_req` is high.
- `wr_ack`  in  1  controller accepts the request.
- `wr_data`  out  32  FIFO head word; valid whenever the FIFO is non-empty.
- `wr_data_rd`  in  1  controller pops one word.
- `overflow`  out  1  sticky flag: at least one word was dropped because the FIFO was full.
- `flush_done`  out  1  one-cycle pulse; all data has been issued after `capture_done`.
- `wr_word_cnt`  out  32  total words popped in the current session.

## Operation

**Packer**
- The first sample of a pair is latched into the low half and `half` is set.
- On the second sample, `{capture_data, low}` is written to the FIFO and `half` is cleared.
- If the FIFO is full at write time, the word is dropped and `overflow` is set. `overflow` clears only on reset or a `sample_en` rise.

**Flush**
- `capture_done` sets `flushing`.
- If `capture_valid` and `capture_done` are high in the same cycle, the sample is packed first.
- If `half` is set while `flushing`, the packer writes `{16'h0000, low}` on the next cycle.
- `capture_valid` is ignored while `flushing`.

**FSM states: IDLE, REQ, DATA, DONE**
- IDLE:
  - If fill ≥ BURST, go to REQ with `wr_len`=BURST.
  - Else if `flushing`, `half` is 0 and fill > 0, go to REQ with `wr_len`=fill.
  - Else if `flushing`, `half` is 0 and fill = 0, go to DONE.
- REQ: `wr_req`=1 with `wr_addr` and `wr_len` held. On `wr_ack`, go to DATA and clear the pop counter.
- DATA:
  - Each `wr_data_rd` with the FIFO non-empty pops one word and increments both the pop counter and `wr_word_cnt`.
  - `wr_data_rd` with the FIFO empty, or outside DATA, is ignored.
  - When the pop counter equals `wr_len`: `wr_addr` += `wr_len` (mod 2^32), go to IDLE.
- DONE: assert `flush_done` for one cycle, clear `flushing`, go to IDLE.

**Arithmetic**
- fill is FIFO_AW+1 bits wide.
- `wr_addr` starts at 0 on each `sample_en` rise.
- The pop counter is 8 bits.

**Session clear**
- A `sample_en` rise at any time clears the FIFO, `half`, `flushing`, `overflow`, `wr_word_cnt` and `wr_addr`, and returns the FSM to IDLE.
- An in-flight burst is abandoned; no further pops are accepted.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty.
- Packer: the word is written on the edge that samples the second half; fill reflects it on the following cycle.
- `wr_req` rises at the earliest one cycle after fill reaches BURST, because the IDLE→REQ decision is registered.
- A pop takes effect on the edge where `wr_data_rd` is high; the next head word appears on `wr_data` the following cycle.
- A simultaneous FIFO write and pop in the same cycle leaves fill unchanged. A write when full is not allowed even if a pop occurs in the same cycle; this keeps the full check simple.
- `flush_done` occurs no earlier than 2 cycles after `capture_done`.
- Reset mid-burst immediately deasserts `wr_req` and clears all counters.

## Structure
- Shared package `capture_wr_pkg`:
  - FSM state enum (IDLE, REQ, DATA, DONE).
  - Pad constant 16'h0000.
  - Width constant for `wr_len`.
- Sub-module `capture_wr_fifo`: synchronous single-clock FIFO, 32 bits × 2^FIFO_AW.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, fill.
  - Uses the same async active-low reset.
- The top level contains the packer, the FSM and the counters.

## Test plan
- **Basic bursts.** BURST=16; 64 back-to-back samples 0..63 → two requests with (addr 0, len 16) and (addr 16, len 16); first popped word 0x0001_0000; `wr_word_cnt`=32.
- **Odd flush.** 5 samples 0xA0..0xA4, then `capture_done` → 3 words, last = 0x0000_00A4; one request with len 3; `flush_done` pulses after the third pop.
- **Simultaneous valid and done.** `capture_valid` with 0x1234 and `capture_done` in the same cycle, after one prior sample 0x5678 → word 0x1234_5678; no pad word.
- **Overflow.** FIFO_AW=2, `wr_ack` held low, 12 samples → 4 words stored, 2 dropped; `overflow`=1 until the next `sample_en` rise.
- **Ack stall.** `wr_ack` held low for 10 cycles → `wr_req`, `wr_addr` and `wr_len` stay stable throughout; no pops are honoured before the ack.
- **Reset mid-burst.** `core_rst_n` low during DATA with 5 of 16 words popped → all outputs 0 next cycle; a new session starts at `wr_addr` 0.
